// File: rtl/morse_pkg.sv
// Shared definitions for the Morse keyer: FSM state encoding, symbol codes
// and the Morse timing ratios expressed in time units.
package morse_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MARK,
        S_GAP_ELEM,
        S_GAP_CHAR,
        S_GAP_WORD
    } state_t;

    localparam logic [5:0] SYM_SPACE = 6'd36;
    localparam logic [5:0] NUM_SYMS  = 6'd37;

    localparam int DOT_U        = 1;
    localparam int DASH_U       = 3;
    localparam int ELEM_GAP_U   = 1;
    localparam int CHAR_GAP_U   = 3;
    localparam int WORD_EXTRA_U = 4;

endpackage

// File: rtl/morse_rom.sv
// Symbol code to Morse element table. Pattern bits are sent MSB-first from
// bit len-1; a 1 is a dash. Anything that is not a letter or digit yields len 0.
module morse_rom
    import morse_pkg::*;
(
    input  logic [5:0] iSYM,
    output logic [2:0] oLEN,
    output logic [4:0] oPAT
);

    logic [7:0] w_entry;

    always_comb begin
        w_entry = 8'd0;
        if (iSYM < NUM_SYMS) begin
            case (iSYM)
                6'd0:  w_entry = {3'd2, 5'b00001};  // A .-
                6'd1:  w_entry = {3'd4, 5'b01000};  // B -...
                6'd2:  w_entry = {3'd4, 5'b01010};  // C -.-.
                6'd3:  w_entry = {3'd3, 5'b00100};  // D -..
                6'd4:  w_entry = {3'd1, 5'b00000};  // E .
                6'd5:  w_entry = {3'd4, 5'b00010};  // F ..-.
                6'd6:  w_entry = {3'd3, 5'b00110};  // G --.
                6'd7:  w_entry = {3'd4, 5'b00000};  // H ....
                6'd8:  w_entry = {3'd2, 5'b00000};  // I ..
                6'd9:  w_entry = {3'd4, 5'b00111};  // J .---
                6'd10: w_entry = {3'd3, 5'b00101};  // K -.-
                6'd11: w_entry = {3'd4, 5'b00100};  // L .-..
                6'd12: w_entry = {3'd2, 5'b00011};  // M --
                6'd13: w_entry = {3'd2, 5'b00010};  // N -.
                6'd14: w_entry = {3'd3, 5'b00111};  // O ---
                6'd15: w_entry = {3'd4, 5'b00110};  // P .--.
                6'd16: w_entry = {3'd4, 5'b01101};  // Q --.-
                6'd17: w_entry = {3'd3, 5'b00010};  // R .-.
                6'd18: w_entry = {3'd3, 5'b00000};  // S ...
                6'd19: w_entry = {3'd1, 5'b00001};  // T -
                6'd20: w_entry = {3'd3, 5'b00001};  // U ..-
                6'd21: w_entry = {3'd4, 5'b00001};  // V ...-
                6'd22: w_entry = {3'd3, 5'b00011};  // W .--
                6'd23: w_entry = {3'd4, 5'b01001};  // X -..-
                6'd24: w_entry = {3'd4, 5'b01011};  // Y -.--
                6'd25: w_entry = {3'd4, 5'b01100};  // Z --..
                6'd26: w_entry = {3'd5, 5'b11111};  // 0
                6'd27: w_entry = {3'd5, 5'b01111};  // 1
                6'd28: w_entry = {3'd5, 5'b00111};  // 2
                6'd29: w_entry = {3'd5, 5'b00011};  // 3
                6'd30: w_entry = {3'd5, 5'b00001};  // 4
                6'd31: w_entry = {3'd5, 5'b00000};  // 5
                6'd32: w_entry = {3'd5, 5'b10000};  // 6
                6'd33: w_entry = {3'd5, 5'b11000};  // 7
                6'd34: w_entry = {3'd5, 5'b11100};  // 8
                6'd35: w_entry = {3'd5, 5'b11110};  // 9
                default: w_entry = 8'd0;            // word space has no elements
            endcase
        end
    end

    assign oLEN = w_entry[7:5];
    assign oPAT = w_entry[4:0];

endmodule

// File: rtl/morse_keyer.sv
// Turns a stream of symbol codes into the on/off keying signal that gates the
// sidetone. All durations are multiples of UNIT_CYCLES clocks.
module morse_keyer
    import morse_pkg::*;
#(
    parameter int UNIT_CYCLES = 6000000,
    parameter int CNT_W       = 25
) (
    input  logic       iCLK,
    input  logic       iRST_N,
    input  logic [5:0] iSYM,
    input  logic       iVALID,
    output logic       oREADY,
    output logic       oPLAY,
    output logic       oBUSY,
    output logic       oDONE
);

    // State durations are (load + 1) cycles, hence the -1 on every load.
    localparam logic [CNT_W-1:0] LD_DOT  = CNT_W'(DOT_U        * UNIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] LD_DASH = CNT_W'(DASH_U       * UNIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] LD_EGAP = CNT_W'(ELEM_GAP_U   * UNIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] LD_CGAP = CNT_W'(CHAR_GAP_U   * UNIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] LD_WORD = CNT_W'(WORD_EXTRA_U * UNIT_CYCLES - 1);

    state_t           r_state;
    logic [CNT_W-1:0] r_timer;
    logic [4:0]       r_pat;
    logic [2:0]       r_idx;
    logic             r_play;
    logic             r_busy;
    logic             r_done;

    logic [2:0]       w_len;
    logic [4:0]       w_pat;
    logic [2:0]       w_first_idx;
    logic             w_first_dash;
    logic             w_timer_zero;

    morse_rom u_rom (
        .iSYM (iSYM),
        .oLEN (w_len),
        .oPAT (w_pat)
    );

    assign w_first_idx  = w_len - 3'd1;
    assign w_first_dash = w_pat[w_first_idx];
    assign w_timer_zero = (r_timer == '0);

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            r_state <= S_IDLE;
            r_timer <= '0;
            r_pat   <= '0;
            r_idx   <= '0;
            r_play  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (iVALID) begin
                        if (iSYM == SYM_SPACE) begin
                            r_state <= S_GAP_WORD;
                            r_timer <= LD_WORD;
                            r_busy  <= 1'b1;
                        end else if (w_len == 3'd0) begin
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= S_MARK;
                            r_timer <= w_first_dash ? LD_DASH : LD_DOT;
                            r_pat   <= w_pat;
                            r_idx   <= w_first_idx;
                            r_play  <= 1'b1;
                            r_busy  <= 1'b1;
                        end
                    end
                end
                S_MARK: begin
                    if (w_timer_zero) begin
                        r_play <= 1'b0;
                        if (r_idx == 3'd0) begin
                            r_state <= S_GAP_CHAR;
                            r_timer <= LD_CGAP;
                        end else begin
                            r_state <= S_GAP_ELEM;
                            r_timer <= LD_EGAP;
                            r_idx   <= r_idx - 3'd1;
                        end
                    end else begin
                        r_timer <= r_timer - CNT_W'(1);
                    end
                end
                S_GAP_ELEM: begin
                    // r_idx already points at the next element
                    if (w_timer_zero) begin
                        r_state <= S_MARK;
                        r_timer <= r_pat[r_idx] ? LD_DASH : LD_DOT;
                        r_play  <= 1'b1;
                    end else begin
                        r_timer <= r_timer - CNT_W'(1);
                    end
                end
                S_GAP_CHAR, S_GAP_WORD: begin
                    if (w_timer_zero) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_timer <= r_timer - CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_timer <= '0;
                    r_play  <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign oREADY = (r_state == S_IDLE);
    assign oPLAY  = r_play;
    assign oBUSY  = r_busy;
    assign oDONE  = r_done;

endmodule

// File: tb/tb_morse_keyer.sv
// Directed bench for morse_keyer with a 4-clock time unit; output traces are
// captured per cycle after the accept edge and compared to hand-built masks.
module tb_morse_keyer;

    logic       iCLK;
    logic       iRST_N;
    logic [5:0] iSYM;
    logic       iVALID;
    logic       oREADY;
    logic       oPLAY;
    logic       oBUSY;
    logic       oDONE;

    int total;
    int bad;

    logic [127:0] play_v, done_v, ready_v, busy_v;

    morse_keyer #(
        .UNIT_CYCLES (4),
        .CNT_W       (8)
    ) dut (
        .iCLK   (iCLK),
        .iRST_N (iRST_N),
        .iSYM   (iSYM),
        .iVALID (iVALID),
        .oREADY (oREADY),
        .oPLAY  (oPLAY),
        .oBUSY  (oBUSY),
        .oDONE  (oDONE)
    );

    initial iCLK = 1'b0;
    always #5 iCLK = ~iCLK;

    function automatic logic [127:0] mask(input int lo, input int hi);
        logic [127:0] m;
        m = '0;
        for (int i = lo; i <= hi; i++) m[i] = 1'b1;
        return m;
    endfunction

    task automatic clear_tr();
        play_v  = '0;
        done_v  = '0;
        ready_v = '0;
        busy_v  = '0;
    endtask

    // bit k holds the outputs one step after the k-th rising edge; edge 0 is the accept
    task automatic capture(input int a, input int b);
        for (int k = a; k <= b; k++) begin
            @(posedge iCLK);
            #1;
            play_v[k]  = oPLAY;
            done_v[k]  = oDONE;
            ready_v[k] = oREADY;
            busy_v[k]  = oBUSY;
        end
    endtask

    task automatic test_reset();
        iRST_N = 1'b1;
        iVALID = 1'b0;
        iSYM   = 6'd0;
        #2 iRST_N = 1'b0;
        #10;
        total++; if (oPLAY !== 1'b0) begin bad++; $display("FAIL reset_play got=%b want=0", oPLAY); end
        total++; if (oBUSY !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", oBUSY); end
        total++; if (oDONE !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", oDONE); end
        @(negedge iCLK);
        iRST_N = 1'b1;
        @(posedge iCLK);
        #1;
        total++; if (oREADY !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", oREADY); end
    endtask

    task automatic test_letter_e();
        clear_tr();
        iSYM = 6'd4; iVALID = 1'b1;
        capture(0, 0);
        iVALID = 1'b0;
        capture(1, 16);
        total++; if (play_v !== mask(0, 3)) begin bad++; $display("FAIL E_play got=%h want=%h", play_v, mask(0, 3)); end
        total++; if (done_v !== mask(16, 16)) begin bad++; $display("FAIL E_done got=%h want=%h", done_v, mask(16, 16)); end
        total++; if (ready_v !== mask(16, 16)) begin bad++; $display("FAIL E_ready got=%h want=%h", ready_v, mask(16, 16)); end
        total++; if (busy_v !== mask(0, 15)) begin bad++; $display("FAIL E_busy got=%h want=%h", busy_v, mask(0, 15)); end
    endtask

    task automatic test_letter_a();
        clear_tr();
        iSYM = 6'd0; iVALID = 1'b1;
        capture(0, 0);
        iVALID = 1'b0;
        capture(1, 32);
        total++; if (play_v !== (mask(0, 3) | mask(8, 19))) begin bad++; $display("FAIL A_play got=%h want=%h", play_v, mask(0, 3) | mask(8, 19)); end
        total++; if (done_v !== mask(32, 32)) begin bad++; $display("FAIL A_done got=%h want=%h", done_v, mask(32, 32)); end
        total++; if (ready_v !== mask(32, 32)) begin bad++; $display("FAIL A_ready got=%h want=%h", ready_v, mask(32, 32)); end
        total++; if (busy_v !== mask(0, 31)) begin bad++; $display("FAIL A_busy got=%h want=%h", busy_v, mask(0, 31)); end
    endtask

    task automatic test_digit_zero();
        logic [127:0] exp_play;
        exp_play = mask(0, 11) | mask(16, 27) | mask(32, 43) | mask(48, 59) | mask(64, 75);
        clear_tr();
        iSYM = 6'd26; iVALID = 1'b1;
        capture(0, 0);
        iVALID = 1'b0;
        capture(1, 88);
        total++; if (play_v !== exp_play) begin bad++; $display("FAIL zero_play got=%h want=%h", play_v, exp_play); end
        total++; if (done_v !== mask(88, 88)) begin bad++; $display("FAIL zero_done got=%h want=%h", done_v, mask(88, 88)); end
        total++; if (ready_v !== mask(88, 88)) begin bad++; $display("FAIL zero_ready got=%h want=%h", ready_v, mask(88, 88)); end
        total++; if (busy_v !== mask(0, 87)) begin bad++; $display("FAIL zero_busy got=%h want=%h", busy_v, mask(0, 87)); end
    endtask

    task automatic test_back_to_back();
        clear_tr();
        iSYM = 6'd36; iVALID = 1'b1;
        capture(0, 0);
        iSYM = 6'd7;
        capture(1, 8);
        iSYM = 6'd19;
        capture(9, 41);
        iVALID = 1'b0;
        total++; if (play_v !== mask(17, 28)) begin bad++; $display("FAIL b2b_play got=%h want=%h", play_v, mask(17, 28)); end
        total++; if (done_v !== (mask(16, 16) | mask(41, 41))) begin bad++; $display("FAIL b2b_done got=%h want=%h", done_v, mask(16, 16) | mask(41, 41)); end
        total++; if (ready_v !== (mask(16, 16) | mask(41, 41))) begin bad++; $display("FAIL b2b_ready got=%h want=%h", ready_v, mask(16, 16) | mask(41, 41)); end
        total++; if (busy_v !== (mask(0, 15) | mask(17, 40))) begin bad++; $display("FAIL b2b_busy got=%h want=%h", busy_v, mask(0, 15) | mask(17, 40)); end
    endtask

    task automatic test_invalid();
        clear_tr();
        total++; if (oREADY !== 1'b1) begin bad++; $display("FAIL inv_pre_ready got=%b want=1", oREADY); end
        iSYM = 6'd40; iVALID = 1'b1;
        capture(0, 0);
        iVALID = 1'b0;
        capture(1, 3);
        total++; if (play_v !== '0) begin bad++; $display("FAIL inv_play got=%h want=0", play_v); end
        total++; if (done_v !== mask(0, 0)) begin bad++; $display("FAIL inv_done got=%h want=%h", done_v, mask(0, 0)); end
        total++; if (ready_v !== mask(0, 3)) begin bad++; $display("FAIL inv_ready got=%h want=%h", ready_v, mask(0, 3)); end
        total++; if (busy_v !== '0) begin bad++; $display("FAIL inv_busy got=%h want=0", busy_v); end
    endtask

    task automatic test_reset_mid_symbol();
        clear_tr();
        iSYM = 6'd19; iVALID = 1'b1;
        capture(0, 0);
        iVALID = 1'b0;
        capture(1, 5);
        total++; if (play_v !== mask(0, 5)) begin bad++; $display("FAIL rst_pre_play got=%h want=%h", play_v, mask(0, 5)); end
        #2 iRST_N = 1'b0;
        #1;
        total++; if (oPLAY !== 1'b0) begin bad++; $display("FAIL rst_async_play got=%b want=0", oPLAY); end
        total++; if (oBUSY !== 1'b0) begin bad++; $display("FAIL rst_async_busy got=%b want=0", oBUSY); end
        @(negedge iCLK);
        iRST_N = 1'b1;
        @(posedge iCLK);
        #1;
        total++; if (oREADY !== 1'b1) begin bad++; $display("FAIL rst_rel_ready got=%b want=1", oREADY); end
        total++; if (oBUSY !== 1'b0) begin bad++; $display("FAIL rst_rel_busy got=%b want=0", oBUSY); end
        clear_tr();
        iSYM = 6'd4; iVALID = 1'b1;
        capture(0, 0);
        iVALID = 1'b0;
        capture(1, 16);
        total++; if (play_v !== mask(0, 3)) begin bad++; $display("FAIL rst_E_play got=%h want=%h", play_v, mask(0, 3)); end
        total++; if (done_v !== mask(16, 16)) begin bad++; $display("FAIL rst_E_done got=%h want=%h", done_v, mask(16, 16)); end
        total++; if (ready_v !== mask(16, 16)) begin bad++; $display("FAIL rst_E_ready got=%h want=%h", ready_v, mask(16, 16)); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_letter_e();
        test_letter_a();
        test_digit_zero();
        test_back_to_back();
        test_invalid();
        test_reset_mid_symbol();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/morse_keyer.md
Name: morse_keyer

Overview:
- Upstream stage of the tone generator: converts a stream of symbol codes into the on/off keying signal (oPLAY) that gates the 830 Hz sidetone.
- Times dots, dashes and gaps in units of UNIT_CYCLES clocks, using standard Morse ratios.
- Accepts one symbol per valid/ready handshake.
- Runs on the 50 MHz system clock; oPLAY connects directly to the tone block's play input.

Parameters:
- UNIT_CYCLES, 6000000, clocks per Morse time unit (120 ms at 50 MHz, about 10 WPM); must be ≥ 1.
- CNT_W, 25, timer width; must satisfy 2^CNT_W > 4*UNIT_CYCLES.

Ports:
- iCLK  input  1  system clock (CLOCK_50 domain)
- iRST_N  input  1  asynchronous active-low reset
- iSYM  input  6  symbol code: 0-25 = A-Z, 26-35 = digits 0-9, 36 = word space, 37-63 invalid
- iVALID  input  1  iSYM is valid
- oREADY  output  1  keyer can accept a symbol
- oPLAY  output  1  tone enable, registered
- oBUSY  output  1  high whenever state ≠ IDLE
- oDONE  output  1  one-cycle pulse when a symbol (valid or invalid) finishes

Behaviour:
- Reset (asynchronous, iRST_N = 0): state = IDLE, timer = 0, oPLAY = 0, oBUSY = 0, oDONE = 0, oREADY = 1 once reset is released. Reset mid-symbol drops the tone immediately; the symbol is discarded.
- Handshake:
  - oREADY = 1 only in IDLE; accept occurs on a rising edge with iVALID && oREADY.
  - iSYM is sampled only at accept; iVALID high while busy is ignored, with no queueing.
- ROM lookup (combinational): iSYM gives a length (3 bits, 1-5) and a pattern (5 bits). Element order is pattern[len-1] first, down to pattern[0]. Bit = 1 means dash (3 units); bit = 0 means dot (1 unit).
- States: IDLE, MARK, GAP_ELEM, GAP_CHAR, GAP_WORD.
- Transitions:
  - IDLE, accept of a letter/digit → MARK. Load timer with (1 or 3)*UNIT_CYCLES-1 and latch pattern and len. oPLAY = 1 starting the cycle after the accept edge.
  - IDLE, accept of 36 → GAP_WORD, timer = 4*UNIT_CYCLES-1. Together with the preceding 3-unit char gap this gives 7 units.
  - IDLE, accept of an invalid code (37-63) → stays IDLE. oDONE pulses next cycle; oREADY stays 1 (accept-and-drop).
  - MARK, timer == 0, elements remain → GAP_ELEM, timer = UNIT_CYCLES-1, oPLAY = 0.
  - MARK, timer == 0, last element → GAP_CHAR, timer = 3*UNIT_CYCLES-1, oPLAY = 0.
  - GAP_ELEM, timer == 0 → MARK for the next element.
  - GAP_CHAR or GAP_WORD, timer == 0 → IDLE; oDONE = 1 for that cycle; oREADY = 1 from the same cycle.
  - Otherwise the timer decrements by 1.
- Timing: each state lasts exactly (loaded value + 1) cycles.
- Symbol duration, accept edge to the first cycle with oREADY = 1:
  - letters/digits: sum(elements) + (len-1) + 3, in units;
  - space: 4 units;
  - invalid: 1 cycle.
- Back-to-back: a symbol accepted on the IDLE-return cycle starts its MARK with no extra gap cycle.
- Arithmetic: timer loads are compile-time constants computed in CNT_W bits; no runtime multiply. No wrap: the timer never decrements below 0.

Decomposition:
- Shared package morse_pkg:
  - state encoding;
  - SYM_SPACE = 36, NUM_SYMS = 37;
  - unit multipliers DOT_U = 1, DASH_U = 3, ELEM_GAP_U = 1, CHAR_GAP_U = 3, WORD_EXTRA_U = 4.
- Sub-module morse_rom: combinational case table, iSYM → {len[2:0], pattern[4:0]}. For invalid codes it returns len = 0, which the FSM uses to detect invalid symbols.

Test Plan:
- UNIT_CYCLES = 4, send 'E' (4) → oPLAY high 4 cycles, low 12; oDONE pulse, and oREADY back 16 cycles after accept.
- Send 'A' (0, dot-dash) → oPLAY pattern high 4 / low 4 / high 12 / low 12; total 32 cycles.
- Send '0' (26, five dashes) → five 12-cycle marks separated by 4-cycle gaps, then 12 low; total 88 cycles.
- Send 36, then 'T' (19) back-to-back with iVALID held → 16 low cycles, then the 'T' mark starts on the cycle right after the IDLE-return cycle; iSYM changes while busy have no effect.
- Send 40 (invalid) → oPLAY never high; oDONE pulse 1 cycle after accept; oREADY continuously 1.
- Assert iRST_N = 0 mid-dash of 'T' → oPLAY = 0 asynchronously; after release oREADY = 1, oBUSY = 0, and the next 'E' times correctly.
